// File: rtl/core_inst_pkg.sv
// core_inst_pkg: instruction-word field positions, idle word and sequencer states shared with core.
package core_inst_pkg;
  localparam int INST_W       = 38;
  localparam int ALL_ROW_MODE = 37;
  localparam int L0_RD_MODE   = 36;
  localparam int MODE         = 35;
  localparam int DATA_MODE    = 34;
  localparam int ACC          = 33;
  localparam int CEN_PMEM     = 32;
  localparam int WEN_PMEM     = 31;
  localparam int A_PMEM_LSB   = 20;
  localparam int CEN_XMEM     = 19;
  localparam int WEN_XMEM     = 18;
  localparam int A_XMEM_LSB   = 7;
  localparam int OFIFO_RD     = 6;
  localparam int IFIFO_WR     = 5;
  localparam int IFIFO_RD     = 4;
  localparam int L0_RD        = 3;
  localparam int L0_WR        = 2;
  localparam int EXECUTE      = 1;
  localparam int LOAD         = 0;
  localparam logic [INST_W-1:0] IDLE_INST = 38'h1_800C_0000;
  typedef enum logic [2:0] {IDLE, W_FETCH, W_LOAD, EXEC, DRAIN, DONE} state_e;
endpackage

// File: rtl/inst_sequencer.sv
// inst_sequencer: builds the registered core instruction word for one weight-stationary tile pass.
module inst_sequencer
  import core_inst_pkg::*;
#(
  parameter int row = 8,
  parameter int col = 8,
  parameter int aw  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [aw-1:0]     len,
  input  logic [aw-1:0]     w_base,
  input  logic [aw-1:0]     x_base,
  input  logic              acc_en,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);
  state_e state_q, state_d;
  logic [aw:0] cnt_q, cnt_d, len_x;
  logic [aw-1:0] len_q, w_base_q, x_base_q;
  logic acc_q, wr_q, busy_q, done_q, p_rd, x_rd, in_pass;
  logic [1:0] ex_q;
  logic [INST_W-1:0] inst_q, inst_d;
  assign len_x = {1'b0, len_q};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + (aw+1)'(1);
    p_rd = state_q == W_FETCH;
    x_rd = state_q == EXEC && cnt_q < len_x;
    in_pass = state_q != IDLE && state_q != DONE;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = len == '0 ? DONE : W_FETCH;
      end
      W_FETCH: if (cnt_q == (aw+1)'(row - 1)) begin
        state_d = W_LOAD;
        cnt_d = '0;
      end
      W_LOAD: if (cnt_q == (aw+1)'(row + col - 1)) begin
        state_d = EXEC;
        cnt_d = '0;
      end
      EXEC: if (cnt_q == len_x + (aw+1)'(1)) begin
        state_d = DRAIN;
        cnt_d = '0;
      end
      // DRAIN counts only accepted OFIFO reads, so its length follows ofifo_valid
      DRAIN: begin
        cnt_d = cnt_q + (aw+1)'(ofifo_valid);
        if (ofifo_valid && cnt_d == len_x) begin
          state_d = DONE;
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
    inst_d = IDLE_INST;
    inst_d[MODE] = in_pass;
    inst_d[ACC] = acc_q && (state_q == EXEC || state_q == DRAIN);
    inst_d[DATA_MODE] = p_rd;
    inst_d[CEN_PMEM] = !p_rd;
    inst_d[A_PMEM_LSB +: aw] = p_rd ? w_base_q + cnt_q[aw-1:0] : '0;
    inst_d[CEN_XMEM] = !x_rd;
    inst_d[A_XMEM_LSB +: aw] = x_rd ? x_base_q + cnt_q[aw-1:0] : '0;
    inst_d[OFIFO_RD] = state_q == DRAIN && ofifo_valid;
    inst_d[L0_WR] = wr_q;
    inst_d[LOAD] = state_q == W_LOAD && cnt_q < (aw+1)'(row);
    inst_d[L0_RD] = inst_d[LOAD] || ex_q[1];
    inst_d[EXECUTE] = ex_q[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      ex_q <= '0;
      inst_q <= IDLE_INST;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      len_q <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      acc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= p_rd || x_rd;
      ex_q <= {ex_q[0], x_rd};
      inst_q <= inst_d;
      busy_q <= in_pass;
      done_q <= state_q == DONE;
      if (state_q == IDLE && start) begin
        len_q <= len;
        w_base_q <= w_base;
        x_base_q <= x_base;
        acc_q <= acc_en;
      end
    end
  end
  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: directed passes with a scoreboard of expected SRAM addresses and done times.
module tb_inst_sequencer;
  import core_inst_pkg::*;
  localparam int AW = 11;
  typedef struct {int cyc; int len;} done_t;
  logic clk = 0, reset = 1, start = 0, acc_en = 0, ofifo_valid = 1;
  logic [AW-1:0] len = '0, w_base = '0, x_base = '0;
  logic [INST_W-1:0] inst;
  logic busy, done;
  int cyc = 0, n_pass = 0, n_tot = 0;
  int n_exec = 0, n_rd = 0, n_load = 0, n_done = 0, last_rd = -10;
  int pa_q[$], xa_q[$];
  done_t dn_q[$];
  bit sb_on = 1, vmode = 0, cur_acc = 0, mon_on = 0;
  logic en_p = 0, v_p = 0;
  logic [1:0] xh = '0;

  inst_sequencer #(.row(8), .col(8), .aw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .w_base(w_base), .x_base(x_base),
    .acc_en(acc_en), .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1 ofifo_valid = vmode ? !ofifo_valid : 1'b1;
  end

  task automatic chk(string name, longint got, longint exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
  endtask

  // monitor: pops expectations whenever the DUT shows an SRAM access or done
  always @(negedge clk) begin
    done_t e;
    if (mon_on) begin
      if (sb_on && !inst[CEN_PMEM]) begin
        chk("A_pmem", inst[A_PMEM_LSB +: AW], pa_q.size() ? pa_q.pop_front() : -1);
        chk("pmem_wen_dmode", {inst[WEN_PMEM], inst[DATA_MODE]}, 2'b11);
      end
      if (sb_on && !inst[CEN_XMEM]) begin
        chk("A_xmem", inst[A_XMEM_LSB +: AW], xa_q.size() ? xa_q.pop_front() : -1);
        chk("xmem_wen_dmode", {inst[WEN_XMEM], inst[DATA_MODE]}, 2'b10);
      end
      if (done) begin
        n_done++;
        chk("busy_at_done", busy, 0);
        if (sb_on) begin
          if (dn_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = dn_q.pop_front();
            if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
            if (e.len > 0) chk("done_after_last_rd", last_rd, cyc - 1);
          end
        end
      end
      if (inst[OFIFO_RD]) begin
        n_rd++;
        last_rd = cyc;
        chk("ofifo_rd_after_valid", v_p, 1);
      end
      if (inst[EXECUTE]) n_exec++;
      if (inst[LOAD]) n_load++;
      if (!busy) begin
        chk("idle_word", inst, IDLE_INST);
        en_p = 0;
        xh = '0;
      end else begin
        chk("mode_busy", inst[MODE], 1);
        chk("zero_bits", {inst[ALL_ROW_MODE], inst[L0_RD_MODE], inst[IFIFO_WR], inst[IFIFO_RD]}, 0);
        if (inst[L0_WR] || en_p) chk("l0_wr_lag", inst[L0_WR], en_p);
        if (inst[EXECUTE] || xh[1]) chk("execute_lag", inst[EXECUTE], xh[1]);
        if (inst[EXECUTE]) chk("acc", inst[ACC], cur_acc);
        if (inst[L0_RD] || inst[LOAD] || inst[EXECUTE]) chk("l0_rd", inst[L0_RD], inst[LOAD] | inst[EXECUTE]);
        en_p = !inst[CEN_PMEM] || !inst[CEN_XMEM];
        xh = {xh[0], !inst[CEN_XMEM]};
      end
      v_p = ofifo_valid;
    end
  end

  task automatic go(int w, int x, int l, bit a);
    @(posedge clk);
    #1;
    if (sb_on) begin
      for (int k = 0; k < 8; k++) if (l > 0) pa_q.push_back((w + k) % 2048);
      for (int i = 0; i < l; i++) xa_q.push_back((x + i) % 2048);
    end
    w_base = AW'(w);
    x_base = AW'(x);
    len = AW'(l);
    acc_en = a;
    cur_acc = a;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    if (sb_on) dn_q.push_back('{(vmode ? -1 : (l == 0 ? cyc + 1 : cyc + 27 + 2 * l)), l});
  endtask

  task automatic wait_done(string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(name, done, 1);
  endtask

  task automatic pass(int w, int x, int l, bit a);
    int e0, r0, l0, d0;
    e0 = n_exec; r0 = n_rd; l0 = n_load; d0 = n_done;
    go(w, x, l, a);
    wait_done("done_seen");
    repeat (3) @(negedge clk);
    chk("exec_count", n_exec - e0, l);
    chk("ofifo_rd_count", n_rd - r0, l);
    chk("load_count", n_load - l0, l > 0 ? 8 : 0);
    chk("done_count", n_done - d0, 1);
  endtask

  initial begin
    int e0, d0;
    repeat (3) @(posedge clk);
    mon_on = 1;
    #1;
    chk("reset_inst", inst, IDLE_INST);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 0;
    pass(10, 100, 3, 1);
    pass(2044, 2045, 5, 0);
    pass(7, 9, 0, 1);
    vmode = 1;
    pass(20, 30, 4, 1);
    vmode = 0;
    e0 = n_exec;
    d0 = n_done;
    go(5, 50, 4, 1);
    repeat (12) @(posedge clk);
    #1 len = AW'(7);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done("done_seen_restart");
    repeat (5) @(negedge clk);
    chk("restart_exec_count", n_exec - e0, 4);
    chk("restart_done_count", n_done - d0, 1);
    sb_on = 0;
    d0 = n_done;
    go(0, 0, 5, 0);
    repeat (26) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    chk("midexec_reset_inst", inst, IDLE_INST);
    chk("midexec_reset_busy", busy, 0);
    chk("midexec_reset_done", done, 0);
    repeat (60) @(posedge clk);
    chk("no_done_after_reset", n_done - d0, 0);
    sb_on = 1;
    pass(100, 200, 2, 1);
    chk("pa_queue_empty", pa_q.size(), 0);
    chk("xa_queue_empty", xa_q.size(), 0);
    chk("done_queue_empty", dn_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
